// File: rtl/voice_mix_sched.sv
// Time-multiplexed voice mixer: fetches NUM_VOICES samples, then tree-reduces them with one shared halving adder.
// Optional sticky overrun flag (ticks arriving while busy) enabled by defining MIX_OVERRUN_FLAG_EN.
module voice_mix_sched #(
  parameter int WIDTH      = 16,
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic [NUM_VOICES-1:0]   voice_en,
  output logic [VIDX_W-1:0]       voice_sel,
  input  logic signed [WIDTH-1:0] voice_sample,
  output logic signed [WIDTH-1:0] mix_out,
  output logic                    mix_valid,
  output logic                    busy
`ifdef MIX_OVERRUN_FLAG_EN
  ,
  output logic                    overrun,
  input  logic                    overrun_clr
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, REDUCE} state_t;

  state_t                  state_q, state_d;
  logic [VIDX_W-1:0]       k_q, k_d;
  logic [VIDX_W-1:0]       lvl_q, lvl_d;
  logic [VIDX_W-1:0]       p_q, p_d;
  logic signed [WIDTH-1:0] mix_q, mix_d;
  logic                    valid_q, valid_d;
  logic signed [WIDTH-1:0] buf_q [NUM_VOICES];

  logic                    wr_en;
  logic [VIDX_W-1:0]       wr_idx;
  logic signed [WIDTH-1:0] wr_data;

  logic [VIDX_W-1:0]       idx_a, idx_b, last_p;
  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] half;

  // Shared halving adder: operands are the pair (2p, 2p+1) of the current tree level.
  always_comb begin
    idx_a  = p_q << 1;
    idx_b  = idx_a | VIDX_W'(1);
    sum    = {buf_q[idx_a][WIDTH-1], buf_q[idx_a]} + {buf_q[idx_b][WIDTH-1], buf_q[idx_b]};
    half   = sum[WIDTH:1];
    last_p = VIDX_W'((NUM_VOICES >> (int'(lvl_q) + 1)) - 1);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lvl_d   = lvl_q;
    p_d     = p_q;
    mix_d   = mix_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = k_q;
    wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = FETCH;
          k_d     = '0;
        end
      end
      FETCH: begin
        wr_en   = 1'b1;
        wr_idx  = k_q;
        wr_data = voice_en[k_q] ? voice_sample : '0;
        if (k_q == VIDX_W'(NUM_VOICES - 1)) begin
          state_d = REDUCE;
          lvl_d   = '0;
          p_d     = '0;
        end else begin
          k_d = k_q + VIDX_W'(1);
        end
      end
      REDUCE: begin
        wr_en   = 1'b1;
        wr_idx  = p_q;
        wr_data = half;
        if (p_q == last_p) begin
          p_d = '0;
          if (lvl_q == VIDX_W'(VIDX_W - 1)) begin
            mix_d   = half;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            lvl_d = lvl_q + VIDX_W'(1);
          end
        end else begin
          p_d = p_q + VIDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      lvl_q   <= '0;
      p_q     <= '0;
      mix_q   <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lvl_q   <= lvl_d;
      p_q     <= p_d;
      mix_q   <= mix_d;
      valid_q <= valid_d;
      if (wr_en) buf_q[wr_idx] <= wr_data;
    end
  end

  assign voice_sel = k_q;
  assign mix_out   = mix_q;
  assign mix_valid = valid_q;
  assign busy      = (state_q != IDLE);

`ifdef MIX_OVERRUN_FLAG_EN
  logic overrun_q;

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              overrun_q <= 1'b0;
    else if (sample_tick && state_q != IDLE) overrun_q <= 1'b1;
    else if (overrun_clr)                   overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;
`endif

endmodule
